hexstr_serializer: RTL and testbench

- Sequential, parametrised successor to the combinational hex-to-ASCII formatters used in the ARINC429 display/debug path.
- Accepts a DATA_W-bit word over a valid/ready handshake, renders it as a right-justified, space-padded uppercase hex field FIELD_CHARS characters wide.
- Streams the field one ASCII character per handshake to a UART/LCD character sink.
- Also publishes the completed field as a registered parallel string, same byte layout as the existing string buses: first character in the top byte, least-significant nibble in [7:0].

---
 rtl/hexstr_serializer.sv | 143 ++++++++++++++
 tb/tb_hexstr_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hexstr_serializer.sv
// Formats a DATA_W-bit word as a right-justified, padded uppercase hex field and
// streams it one ASCII character per handshake. Optional: HEXSTR_ZERO_SUPPRESS_EN.
module hexstr_serializer #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned FIELD_CHARS = 16,
  parameter logic [7:0]  PAD_CHAR    = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_char,
  output logic                     out_last,
  output logic [FIELD_CHARS*8-1:0] str_out,
  output logic                     str_valid
);

  localparam int unsigned NIB = DATA_W / 4;
  localparam int unsigned FW  = FIELD_CHARS * 8;
  localparam int unsigned IW  = (FIELD_CHARS > 1) ? $clog2(FIELD_CHARS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FIELD_CHARS - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                in_ready_n, out_valid_n, out_last_n, str_valid_n;
  logic [7:0]          out_char_n;
  logic [FW-1:0]       str_out_n;
  logic [DATA_W-1:0]   src;
  logic [FW-1:0]       field;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Whole field, first character in the top byte.
  function automatic logic [FW-1:0] render(input logic [DATA_W-1:0] d);
    logic [FW-1:0] f;
    logic [3:0]    n;
`ifdef HEXSTR_ZERO_SUPPRESS_EN
    logic          lead;
    lead = 1'b1;
`endif
    f = '0;
    for (int c = 0; c < int'(FIELD_CHARS); c++) f[c*8 +: 8] = PAD_CHAR;
    for (int k = 0; k < int'(NIB); k++) begin
      n = d[(int'(NIB) - 1 - k)*4 +: 4];
`ifdef HEXSTR_ZERO_SUPPRESS_EN
      // The least-significant nibble is never suppressed, so zero renders as "0".
      lead = lead && (n == 4'd0) && (k != int'(NIB) - 1);
      f[(int'(NIB) - 1 - k)*8 +: 8] = lead ? PAD_CHAR : hex_ascii(n);
`else
      f[(int'(NIB) - 1 - k)*8 +: 8] = hex_ascii(n);
`endif
    end
    return f;
  endfunction

  function automatic logic [7:0] char_at(input logic [FW-1:0] f, input logic [IW-1:0] i);
    logic [FW-1:0] s;
    s = f >> (8 * (FIELD_CHARS - 1 - 32'(i)));
    return s[7:0];
  endfunction

  // In IDLE the first character comes straight from in_data so it is ready at latency 1.
  assign src   = (state == IDLE) ? in_data : data_q;
  assign field = render(src);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    data_n      = data_q;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_char_n  = out_char;
    out_last_n  = out_last;
    str_out_n   = str_out;
    str_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n     = EMIT;
          data_n      = in_data;
          idx_n       = '0;
          in_ready_n  = 1'b0;
          out_valid_n = 1'b1;
          out_char_n  = char_at(field, '0);
          out_last_n  = (LAST_IDX == '0);
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (idx == LAST_IDX) begin
            state_n     = IDLE;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            str_out_n   = field;
            str_valid_n = 1'b1;
          end else begin
            idx_n       = idx + IW'(1);
            out_char_n  = char_at(field, idx + IW'(1));
            out_last_n  = ((idx + IW'(1)) == LAST_IDX);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      str_out   <= '0;
      str_valid <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      data_q    <= data_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_char  <= out_char_n;
      out_last  <= out_last_n;
      str_out   <= str_out_n;
      str_valid <= str_valid_n;
    end
  end

endmodule

// File: tb/tb_hexstr_serializer.sv
// Self-checking bench for hexstr_serializer: directed and randomized words against
// a string-level reference model, plus a DATA_W=4 / FIELD_CHARS=1 corner instance.
module tb_hexstr_serializer;

  localparam int DW  = 24;
  localparam int FC  = 16;
  localparam int NIB = DW / 4;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_last, str_valid;
  logic [DW-1:0] in_data;
  logic [7:0]   out_char;
  logic [FC*8-1:0] str_out;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_str_valid;
  logic [3:0]   s_in_data;
  logic [7:0]   s_out_char, s_str_out;

  int checks   = 0;
  int failures = 0;

  hexstr_serializer #(.DATA_W(DW), .FIELD_CHARS(FC), .PAD_CHAR(8'h20)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_last(out_last),
    .str_out(str_out), .str_valid(str_valid)
  );

  hexstr_serializer #(.DATA_W(4), .FIELD_CHARS(1), .PAD_CHAR(8'h20)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_char(s_out_char), .out_last(s_out_last),
    .str_out(s_str_out), .str_valid(s_str_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: build the field as a character sequence, then pack first char on top.
  function automatic logic [127:0] model(input logic [63:0] d, input int nib, input int fc);
    string        hexs;
    int           first_nz, pads, k;
    logic [3:0]   nv;
    logic [127:0] r;
    byte          q[$];
    hexs = "0123456789ABCDEF";
    first_nz = nib - 1;
    for (int i = nib - 1; i >= 0; i--)
      if (((d >> ((nib - 1 - i) * 4)) & 64'hF) != 0) first_nz = i;
`ifdef HEXSTR_ZERO_SUPPRESS_EN
    pads = fc - (nib - first_nz);
`else
    pads = fc - nib;
`endif
    for (int c = 0; c < fc; c++) begin
      if (c < pads) q.push_back(8'h20);
      else begin
        k  = c - (fc - nib);
        nv = 4'((d >> ((nib - 1 - k) * 4)) & 64'hF);
        q.push_back(hexs[nv]);
      end
    end
    r = '0;
    foreach (q[i]) r = {r[119:0], q[i]};
    return r;
  endfunction

  // Runs one field already accepted; mode 0: ready=1, 1: alternate with 3-cycle stall at char 12, 2: random.
  task automatic emit_check(input logic [127:0] exp, input int mode);
    int idx = 0, ncyc = 0, hold = 0;
    logic rdy;
    logic [7:0] e;
    check("str_valid_low", 128'(str_valid), 128'(0));
    while (idx < FC && ncyc < 300) begin
      e = exp[(FC - 1 - idx) * 8 +: 8];
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) begin
        rdy = (ncyc % 2 == 0);
        if (idx == 12 && hold < 3) begin rdy = 1'b0; hold++; end
      end else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      check("out_valid", 128'(out_valid), 128'(1));
      check("in_ready_emit", 128'(in_ready), 128'(0));
      check("out_char", 128'(out_char), 128'(e));
      check("out_last", 128'(out_last), 128'(idx == FC - 1));
      cyc();
      ncyc++;
      if (rdy) idx++;
    end
    if (idx < FC) check("emit_timeout", 128'(idx), 128'(FC));
    if (mode == 0) check("field_cycles", 128'(ncyc), 128'(FC));
    check("str_valid_pulse", 128'(str_valid), 128'(1));
    check("str_out", str_out, exp);
    check("in_ready_idle", 128'(in_ready), 128'(1));
    check("out_valid_idle", 128'(out_valid), 128'(0));
  endtask

  task automatic accept(input logic [DW-1:0] w);
    int n = 0;
    while (!in_ready && n < 50) begin cyc(); n++; end
    in_valid = 1'b1;
    in_data  = w;
    cyc();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic send(input logic [DW-1:0] w, input int mode);
    accept(w);
    emit_check(model(64'(w), NIB, FC), mode);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [127:0]  tp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
    cyc(); cyc();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_char", 128'(out_char), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_str_out", str_out, 128'(0));
    check("rst_str_valid", 128'(str_valid), 128'(0));
    rst_n = 1'b1;
    cyc();

`ifdef HEXSTR_ZERO_SUPPRESS_EN
    tp = {{11{8'h20}}, "A3F00"};
`else
    tp = {{10{8'h20}}, "0A3F00"};
`endif
    send(24'h0A3F00, 0);
    check("tp_0A3F00", str_out, tp);
    send(24'h000000, 0);
    send(24'hFFFFFF, 0);
    send(24'h0A3F00, 1);
    check("tp_backpressure", str_out, tp);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_data  = 24'h123456;
    cyc();
    in_data  = 24'hABCDEF;
    emit_check(model(64'h123456, NIB, FC), 0);
    cyc();
    in_valid = 1'b0;
    emit_check(model(64'hABCDEF, NIB, FC), 0);

    // Reset after the 5th transfer.
    accept(24'h5A5A5A);
    out_ready = 1'b1;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_str_out", str_out, 128'(0));
    check("mid_rst_str_valid", 128'(str_valid), 128'(0));
    check("mid_rst_out_char", 128'(out_char), 128'(0));
    cyc();
    check("post_rst_str_valid", 128'(str_valid), 128'(0));
    check("post_rst_out_valid", 128'(out_valid), 128'(0));
    send(24'h00BEEF, 0);

    for (int i = 0; i < 20; i++) begin
      w = DW'($urandom) >> (4 * $urandom_range(0, 6));
      send(w, 2);
    end

    // Single-character field.
    for (int v = 0; v < 17; v++) begin
      s_in_data  = (v == 0) ? 4'hC : 4'(v - 1);
      tp         = model(64'(s_in_data), 1, 1);
      s_in_valid = 1'b1;
      s_out_ready = 1'b0;
      cyc();
      s_in_valid = 1'b0;
      check("s_out_valid", 128'(s_out_valid), 128'(1));
      check("s_out_char", 128'(s_out_char), 128'(tp[7:0]));
      check("s_out_last", 128'(s_out_last), 128'(1));
      s_out_ready = 1'b1;
      cyc();
      check("s_str_valid", 128'(s_str_valid), 128'(1));
      check("s_str_out", 128'(s_str_out), 128'(tp[7:0]));
      check("s_in_ready", 128'(s_in_ready), 128'(1));
      if (v == 0) check("s_tp_C", 128'(s_str_out), 128'(8'h43));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
